// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared types and constants for the PS/2 host receiver:
//                receiver FSM state encoding, prefix byte values and the
//                number of data bits per frame.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_rx_state_t;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
  localparam int         PS2_DATA_BITS  = 8;

endpackage
`default_nettype wire

// File: rtl/ps2_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_sync_edge
//  Description : Two-flop synchronisers for the PS/2 clock and data pins plus
//                a falling-edge detector on the synchronised clock.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk_i      in  system clock
//    reset_i    in  synchronous active-high reset
//    ps2_clk_i  in  raw PS/2 clock pin (asynchronous)
//    ps2_dat_i  in  raw PS/2 data pin (asynchronous)
//    clk_s_o    out synchronised PS/2 clock
//    dat_s_o    out synchronised PS/2 data
//    fall_o     out one-cycle pulse on a falling edge of the synchronised clock
// ============================================================================
module ps2_sync_edge (
  input  logic clk_i,
  input  logic reset_i,
  input  logic ps2_clk_i,
  input  logic ps2_dat_i,
  output logic clk_s_o,
  output logic dat_s_o,
  output logic fall_o
);

  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic dat_meta_q, dat_sync_q;

  // All flops reset to the idle-high line level so leaving reset can never
  // manufacture a falling edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= ps2_clk_i;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= ps2_dat_i;
      dat_sync_q <= dat_meta_q;
    end
  end

  assign clk_s_o = clk_sync_q;
  assign dat_s_o = dat_sync_q;
  assign fall_o  = clk_prev_q & ~clk_sync_q;

endmodule
`default_nettype wire

// File: rtl/ps2_host_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_host_rx
//  Description : Host-side PS/2 receiver. Deserialises 11-bit frames sampled
//                on falling PS/2 clock edges, checks odd parity and the stop
//                bit, strips E0/F0 prefixes and emits one qualified scan code
//                per key event.
//  Revision    : 1.0 - initial release
//
//  Configuration macro: PS2_HOST_RX_TIMEOUT_EN enables a mid-frame watchdog
//  of TIMEOUT_CYCLES system clocks that abandons a stalled frame with a
//  frame_err pulse. Without it a partial frame waits for further edges.
//
//  Ports
//    CLOCK_50     in  system clock
//    reset        in  synchronous active-high reset
//    ps2_clk      in  PS/2 clock from device (asynchronous, idles high)
//    ps2_dat      in  PS/2 data from device (asynchronous, idles high)
//    scan_code    out last completed scan code, prefixes removed
//    scan_valid   out one-cycle pulse when scan_code/flags update
//    is_break     out code was preceded by F0
//    is_extended  out code was preceded by E0
//    parity_err   out one-cycle pulse, frame failed odd parity
//    frame_err    out one-cycle pulse, bad stop bit or timeout
//    busy         out high while a frame is in progress
// ============================================================================
module ps2_host_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       is_break,
  output logic       is_extended,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  logic          clk_s, dat_s, fall;
  ps2_rx_state_t state_q;
  logic [7:0]    shift_q;
  logic [2:0]    bit_cnt_q;
  logic          parity_q;
  logic          ext_pend_q, brk_pend_q;
  logic          timeout_d;
  logic          parity_ok_d;

  ps2_sync_edge u_sync (
    .clk_i     (CLOCK_50),
    .reset_i   (reset),
    .ps2_clk_i (ps2_clk),
    .ps2_dat_i (ps2_dat),
    .clk_s_o   (clk_s),
    .dat_s_o   (dat_s),
    .fall_o    (fall)
  );

  // Odd parity: data plus parity bit must hold an odd number of ones.
  assign parity_ok_d = ^{shift_q, parity_q};

`ifdef PS2_HOST_RX_TIMEOUT_EN
  localparam logic [16:0] WDOG_LAST = 17'(TIMEOUT_CYCLES - 1);
  logic [16:0] wdog_q;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wdog_q <= '0;
    end else if (fall || state_q == IDLE) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_q + 17'd1;
    end
  end

  // A fall arriving on the expiry cycle keeps the frame alive.
  assign timeout_d = (state_q != IDLE) && !fall && (wdog_q == WDOG_LAST);
`else
  assign timeout_d = 1'b0;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      parity_q    <= 1'b0;
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
      scan_code   <= '0;
      scan_valid  <= 1'b0;
      is_break    <= 1'b0;
      is_extended <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      scan_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;

      if (timeout_d) begin
        state_q    <= IDLE;
        busy       <= 1'b0;
        frame_err  <= 1'b1;
        ext_pend_q <= 1'b0;
        brk_pend_q <= 1'b0;
      end else if (fall) begin
        case (state_q)
          IDLE: begin
            // A high level on a falling edge is not a start bit.
            if (!dat_s) begin
              shift_q   <= '0;
              bit_cnt_q <= '0;
              state_q   <= DATA;
              busy      <= 1'b1;
            end
          end
          DATA: begin
            // LSB arrives first, so shift right from the top.
            shift_q   <= {dat_s, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'(PS2_DATA_BITS - 1)) begin
              state_q <= PARITY;
            end
          end
          PARITY: begin
            parity_q <= dat_s;
            state_q  <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            busy    <= 1'b0;
            if (!dat_s) begin
              frame_err  <= 1'b1;
              ext_pend_q <= 1'b0;
              brk_pend_q <= 1'b0;
            end else if (!parity_ok_d) begin
              parity_err <= 1'b1;
              ext_pend_q <= 1'b0;
              brk_pend_q <= 1'b0;
            end else if (shift_q == PS2_PREFIX_EXT) begin
              ext_pend_q <= 1'b1;
            end else if (shift_q == PS2_PREFIX_BRK) begin
              brk_pend_q <= 1'b1;
            end else begin
              scan_code   <= shift_q;
              is_break    <= brk_pend_q;
              is_extended <= ext_pend_q;
              scan_valid  <= 1'b1;
              ext_pend_q  <= 1'b0;
              brk_pend_q  <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
